fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Byte-at-a-time UART transmitter that pops one byte per frame from an upstream FIFO.
// Optional even parity bit compiled in with `define UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd6
  } state_t;
`endif

  state_t           state_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;

  // Outputs are assigned together with the state transition so each one is
  // a flop whose value lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      fifo_rd_en   <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      done       <= 1'b0;
      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          tx           <= 1'b1;
          if (en && !fifo_empty) begin
            state_reg  <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: begin
          state_reg <= LOAD;
        end
        LOAD: begin
          shift_reg    <= fifo_dout;
          baud_cnt_reg <= '0;
          state_reg    <= START;
          tx           <= 1'b0;
        end
        START: begin
          if (baud_cnt_reg == CNT_LAST) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= DATA;
            tx           <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_reg == CNT_LAST) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= PARITY;
              tx        <= ^shift_reg;
`else
              state_reg <= STOP;
              tx        <= 1'b1;
`endif
            end else begin
              tx <= shift_reg[bit_idx_reg + 3'd1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt_reg == CNT_LAST) begin
            baud_cnt_reg <= '0;
            state_reg    <= STOP;
            tx           <= 1'b1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt_reg == CNT_LAST) begin
            baud_cnt_reg <= '0;
            state_reg    <= IDLE;
            busy         <= 1'b0;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
            // Raised one cycle early so the registered pulse sits on the final stop cycle.
            if (baud_cnt_reg == CNT_PRE_LAST) begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          baud_cnt_reg <= '0;
          tx           <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: FIFO model feeds bytes, a line receiver checks every frame.
// Follows the DUT build: define UART_TX_PARITY_EN for both to test the parity frame.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;
  localparam int BUSY_CYC  = 2 + FRAME_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, tx, busy, done;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  int rd_pulses = 0, rd_double = 0, done_cnt = 0, aborted = 0, frames = 0;
  logic rd_prev = 1'b0, dout_hold = 1'b0;

  logic mon_active = 1'b0;
  int   mon_cyc = 0, gap_cnt = 0, last_gap = 0, busy_run = 0;
  logic samp  [0:63];
  logic dsamp [0:63];
  logic ebits [0:NBITS-1];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Upstream FIFO: data appears the cycle after the read strobe, garbage otherwise.
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses++;
      if (rd_prev) rd_double++;
      if (fifo_q.size() > 0) begin
        fifo_dout = fifo_q.pop_front();
        exp_q.push_back(fifo_dout);
      end
      dout_hold = 1'b1;
    end else if (dout_hold) begin
      dout_hold = 1'b0;
    end else begin
      fifo_dout = 8'($urandom);
    end
    rd_prev    = fifo_rd_en;
    fifo_empty = (fifo_q.size() == 0);
  end

  // Line receiver: records a full frame of samples and compares against the ideal waveform.
  always @(negedge clk) begin
    logic [7:0] b;
    logic [7:0] rx;
    int mism, dmism;
    if (done) done_cnt++;
    if (!rst_n) begin
      if (mon_active && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        aborted++;
      end
      mon_active = 1'b0;
      busy_run   = 0;
      gap_cnt    = 0;
    end else begin
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", busy_run, BUSY_CYC);
        busy_run = 0;
      end
      if (!mon_active) begin
        if (tx == 1'b0) begin
          mon_active = 1'b1;
          mon_cyc    = 0;
          samp[0]    = tx;
          dsamp[0]   = done;
          last_gap   = gap_cnt;
        end else begin
          gap_cnt++;
        end
      end else begin
        mon_cyc++;
        samp[mon_cyc]  = tx;
        dsamp[mon_cyc] = done;
        if (mon_cyc == FRAME_CYC - 1) begin
          mon_active = 1'b0;
          gap_cnt    = 0;
          frames++;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            b = exp_q.pop_front();
            ebits[0] = 1'b0;
            for (int k = 0; k < 8; k++) ebits[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
            ebits[9] = ^b;
`endif
            ebits[NBITS-1] = 1'b1;
            mism  = 0;
            dmism = 0;
            for (int c = 0; c < FRAME_CYC; c++) begin
              if (samp[c] !== ebits[c / CPB]) mism++;
              if (dsamp[c] !== (c == FRAME_CYC - 1)) dmism++;
            end
            for (int k = 0; k < 8; k++) rx[k] = samp[(k + 1) * CPB + CPB / 2];
            check("frame_byte", int'(rx), int'(b));
            check("frame_shape", mism, 0);
            check("done_pulse", dmism, 0);
            $display("frame %0d: sent 0x%02h, received 0x%02h, gap %0d", frames, b, rx, last_gap);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic wait_drain(input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy && !mon_active) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", int'(ok), 1);
  endtask

  initial begin
    int rd0, done0, ab0, v_rd, v_tx, v_busy;
    logic seen;

    // Reset held with a non-empty FIFO and enable high.
    en = 1'b1;
    push(8'h5A);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("rst_tx", int'(tx), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_rd_en", int'(fifo_rd_en), 0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rd_after_release", int'(fifo_rd_en), 0);
    wait_drain(200);

    // Single byte 0xA5.
    rd0 = rd_pulses; done0 = done_cnt;
    tick();
    push(8'hA5);
    wait_drain(200);
    check("a5_rd_pulses", rd_pulses - rd0, 1);
    check("a5_done_pulses", done_cnt - done0, 1);

    // Empty FIFO with enable held high.
    v_rd = 0; v_tx = 0; v_busy = 0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (fifo_rd_en) v_rd++;
      if (!tx) v_tx++;
      if (busy) v_busy++;
    end
    check("empty_rd_en", v_rd, 0);
    check("empty_tx_low", v_tx, 0);
    check("empty_busy", v_busy, 0);

    // Back-to-back 0x00 then 0xFF.
    rd0 = rd_pulses;
    tick();
    push(8'h00);
    push(8'hFF);
    wait_drain(400);
    check("b2b_rd_pulses", rd_pulses - rd0, 2);
    check("b2b_gap", last_gap, 3);

    // Parity-sensitive pair.
    tick();
    push(8'h07);
    push(8'h03);
    wait_drain(400);

    // Enable dropped mid-frame: frame completes, second byte stays queued.
    tick();
    en = 1'b0;
    rd0 = rd_pulses;
    push(8'($urandom));
    push(8'($urandom));
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (rd_pulses != rd0) begin
        seen = 1'b1;
        break;
      end
    end
    check("endrop_fetch_seen", int'(seen), 1);
    repeat (5) tick();
    en = 1'b0;
    repeat (FRAME_CYC + 20) tick();
    check("endrop_rd_pulses", rd_pulses - rd0, 1);
    check("endrop_fifo_left", fifo_q.size(), 1);
    check("endrop_busy", int'(busy), 0);
    en = 1'b1;
    wait_drain(400);

    // Reset in the middle of data bit 3.
    rd0 = rd_pulses; ab0 = aborted;
    tick();
    push(8'h3C);
    push(8'hC3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mon_active) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstmid_start_seen", int'(seen), 1);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid_tx", int'(tx), 1);
    check("rstmid_busy", int'(busy), 0);
    tick();
    en = 1'b0;
    rst_n = 1'b1;
    v_busy = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (busy) v_busy++;
    end
    check("rstmid_idle_busy", v_busy, 0);
    check("rstmid_rd_hold", rd_pulses - rd0, 1);
    check("rstmid_aborted", aborted - ab0, 1);
    en = 1'b1;
    wait_drain(400);
    check("rstmid_rd_total", rd_pulses - rd0, 2);

    // Randomized bursts with random idle spacing.
    for (int n = 0; n < 12; n++) begin
      tick();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) push(8'($urandom));
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_drain(3000);

    check("rd_double", rd_double, 0);
    check("exp_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
